// File: rtl/stage_execute_vmc.sv
// stage_execute_vmc: vector execute stage with per-lane ALUs, operand
// forwarding, branch resolution, the EX/MEM pipeline register and an
// optional iterative lane multiplier.
// Optional feature macro: EX_MUL_EN (multi-cycle multiplier FSM, ex_busy).
// Without EX_MUL_EN the multiply opcode is a single-cycle ALU op.

// Lane ALU: one 32-bit lane, comparison flags taken from the operands.
module alu #(
    parameter logic [3:0] MUL_CODE = 4'b1010,
    parameter bit         HAS_MUL  = 1'b1
) (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_ctrl,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_lt,
    output logic        o_ltu
);
    logic w_lt;
    logic w_ltu;

    assign w_lt  = $signed(i_a) < $signed(i_b);
    assign w_ltu = i_a < i_b;

    // Operation decode
    always_comb begin
        o_result = '0;
        if (HAS_MUL && (i_ctrl == MUL_CODE)) begin
            o_result = i_a * i_b;
        end else begin
            case (i_ctrl)
                4'd0:    o_result = i_a + i_b;
                4'd1:    o_result = i_a - i_b;
                4'd2:    o_result = i_a & i_b;
                4'd3:    o_result = i_a | i_b;
                4'd4:    o_result = i_a ^ i_b;
                4'd5:    o_result = {31'b0, w_lt};
                4'd6:    o_result = {31'b0, w_ltu};
                4'd7:    o_result = i_a << i_b[4:0];
                4'd8:    o_result = i_a >> i_b[4:0];
                4'd9:    o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
                default: o_result = '0;
            endcase
        end
    end

    assign o_zero = (o_result == '0);
    assign o_lt   = w_lt;
    assign o_ltu  = w_ltu;
endmodule

// Branch condition evaluation from lane 0 flags (funct3-style types).
module jump_cond_ctrl (
    input  logic [2:0] i_type,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_cond_true
);
    // Condition select
    always_comb begin
        o_cond_true = 1'b0;
        case (i_type)
            3'b000:  o_cond_true = i_zero;
            3'b001:  o_cond_true = ~i_zero;
            3'b100:  o_cond_true = i_lt;
            3'b101:  o_cond_true = ~i_lt;
            3'b110:  o_cond_true = i_ltu;
            3'b111:  o_cond_true = ~i_ltu;
            default: o_cond_true = 1'b0;
        endcase
    end
endmodule

module stage_execute_vmc #(
    parameter int         LANES    = 4,
    parameter int         MUL_STEP = 8,
    parameter logic [3:0] MUL_CODE = 4'b1010
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_clear,
    input  logic                  mem_stall,
    input  logic                  ex_flush,
    input  logic [31:0]           ex_instr,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_jump,
    input  logic                  ex_jump_cond,
    input  logic                  ex_alu_src_op1,
    input  logic                  ex_alu_src_op2,
    input  logic                  ex_pc_target_src,
    input  logic                  ex_vector_op,
    input  logic [2:0]            ex_jump_cond_type,
    input  logic [3:0]            ex_alu_control,
    input  logic [1:0]            ex_result_src,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_pc_plus_4,
    input  logic [31:0]           ex_imm_ext,
    input  logic [32*LANES-1:0]   ex_rd1,
    input  logic [32*LANES-1:0]   ex_rd2,
    input  logic [4:0]            ex_rd,
    input  logic [32*LANES-1:0]   wb_result,
    input  logic [1:0]            ex_op1_forward,
    input  logic [1:0]            ex_op2_forward,
    output logic [31:0]           mem_instr,
    output logic                  mem_reg_write,
    output logic                  mem_mem_write,
    output logic                  mem_mem_read,
    output logic                  mem_vector_op,
    output logic [1:0]            mem_result_src,
    output logic [32*LANES-1:0]   mem_alu_result,
    output logic [32*LANES-1:0]   mem_write_data,
    output logic [32*LANES-1:0]   mem_imm_ext,
    output logic [31:0]           mem_pc_plus_4,
    output logic [4:0]            mem_rd,
    output logic                  ex_pc_src,
    output logic [31:0]           ex_pc_target,
    output logic                  ex_busy
);
    localparam int VW = 32 * LANES;

`ifdef EX_MUL_EN
    localparam bit ALU_MUL = 1'b0;
`else
    localparam bit ALU_MUL = 1'b1;
`endif

    // EX/MEM pipeline register
    logic [31:0]   r_instr;
    logic          r_reg_write;
    logic          r_mem_write;
    logic          r_mem_read;
    logic          r_vector_op;
    logic [1:0]    r_result_src;
    logic [VW-1:0] r_alu_result;
    logic [VW-1:0] r_write_data;
    logic [VW-1:0] r_imm_ext;
    logic [31:0]   r_pc_plus_4;
    logic [4:0]    r_rd;

    logic [VW-1:0]    w_rd1_fwd;
    logic [VW-1:0]    w_rd2_fwd;
    logic [VW-1:0]    w_mem_op2;
    logic [VW-1:0]    w_op1;
    logic [VW-1:0]    w_op2;
    logic [VW-1:0]    w_alu_res;
    logic [VW-1:0]    w_lane_res;
    logic [VW-1:0]    w_result;
    logic [LANES-1:0] w_zero;
    logic [LANES-1:0] w_lt;
    logic [LANES-1:0] w_ltu;
    logic             w_unused_flags;
    logic             w_cond_true;
    logic             w_scalar;
    logic             w_busy;
    logic             w_mul_done;
    logic             w_bubble;

    // Operand forwarding; scalar MEM results feed op2 as a lane 0 broadcast
    always_comb begin
        w_mem_op2 = mem_vector_op ? r_alu_result : {LANES{r_alu_result[31:0]}};
        case (ex_op1_forward)
            2'b01:   w_rd1_fwd = wb_result;
            2'b10:   w_rd1_fwd = r_alu_result;
            default: w_rd1_fwd = ex_rd1;
        endcase
        case (ex_op2_forward)
            2'b01:   w_rd2_fwd = wb_result;
            2'b10:   w_rd2_fwd = w_mem_op2;
            default: w_rd2_fwd = ex_rd2;
        endcase
    end

    assign w_op1 = ex_alu_src_op1 ? w_rd1_fwd : '0;
    assign w_op2 = ex_alu_src_op2 ? {LANES{ex_imm_ext}} : w_rd2_fwd;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            alu #(
                .MUL_CODE (MUL_CODE),
                .HAS_MUL  (ALU_MUL)
            ) u_alu (
                .i_a      (w_op1[32*g +: 32]),
                .i_b      (w_op2[32*g +: 32]),
                .i_ctrl   (ex_alu_control),
                .o_result (w_alu_res[32*g +: 32]),
                .o_zero   (w_zero[g]),
                .o_lt     (w_lt[g]),
                .o_ltu    (w_ltu[g])
            );
        end
    endgenerate

    // Only lane 0 flags steer branches
    assign w_unused_flags = &{w_zero, w_lt, w_ltu};

    jump_cond_ctrl u_jump_cond (
        .i_type      (ex_jump_cond_type),
        .i_zero      (w_zero[0]),
        .i_lt        (w_lt[0]),
        .i_ltu       (w_ltu[0]),
        .o_cond_true (w_cond_true)
    );

    assign ex_pc_target = ex_pc_target_src ? w_alu_res[31:0] : (ex_pc + ex_imm_ext);
    assign ex_pc_src    = ((ex_jump_cond & w_cond_true) | ex_jump) & ~reset;

`ifdef EX_MUL_EN
    localparam int NSTEPS = 32 / MUL_STEP;
    localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(NSTEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_start;
    logic [CNT_W-1:0] r_count;
    logic [VW-1:0]    r_acc;
    logic [VW-1:0]    r_mop1;
    logic [VW-1:0]    r_mop2;
    logic [VW-1:0]    w_partial;

    // Multiplier state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, start strobe and stall request; flush/reset abort at once
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ex_alu_control == MUL_CODE) begin
                    w_start = 1'b1;
                    w_busy  = 1'b1;
                    w_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (r_count == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!mem_stall) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (ex_flush || reset) begin
            w_next  = S_IDLE;
            w_start = 1'b0;
            w_busy  = 1'b0;
        end
    end

    // One MUL_STEP-bit digit of op2 times the pre-shifted op1, per lane
    always_comb begin
        w_partial = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_partial[32*l +: 32] = r_mop1[32*l +: 32] * 32'(r_mop2[32*l +: MUL_STEP]);
        end
    end

    // Operand latch and shift-and-add accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_mop1  <= '0;
            r_mop2  <= '0;
            r_count <= '0;
        end else if (w_start) begin
            r_acc   <= '0;
            r_mop1  <= w_op1;
            r_mop2  <= w_op2;
            r_count <= CNT_START;
        end else if (r_state == S_BUSY) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                r_acc[32*l +: 32]  <= r_acc[32*l +: 32] + w_partial[32*l +: 32];
                r_mop1[32*l +: 32] <= r_mop1[32*l +: 32] << MUL_STEP;
                r_mop2[32*l +: 32] <= r_mop2[32*l +: 32] >> MUL_STEP;
            end
            r_count <= r_count - 1'b1;
        end
    end

    assign w_mul_done = (r_state == S_DONE);
    assign w_lane_res = w_mul_done ? r_acc : w_alu_res;
`else
    assign w_busy     = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_lane_res = w_alu_res;
`endif

    assign ex_busy = w_busy;

    // Scalar ops and memory ops broadcast lane 0
    assign w_scalar = ~ex_vector_op | ex_mem_read | ex_mem_write;
    assign w_result = w_scalar ? {LANES{w_lane_res[31:0]}} : w_lane_res;

    // A flushed EX instruction is dropped along with any multiply
    assign w_bubble = w_busy | ex_flush;

    // EX/MEM register: reset > clear > stall hold > bubble > load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr      <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_vector_op  <= 1'b0;
            r_result_src <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_imm_ext    <= '0;
            r_pc_plus_4  <= '0;
            r_rd         <= '0;
        end else if (mem_clear || (!mem_stall && w_bubble)) begin
            r_instr      <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_vector_op  <= 1'b0;
            r_result_src <= '0;
            r_rd         <= '0;
        end else if (!mem_stall) begin
            r_instr      <= ex_instr;
            r_reg_write  <= ex_reg_write;
            r_mem_write  <= ex_mem_write;
            r_mem_read   <= ex_mem_read;
            r_vector_op  <= ex_vector_op;
            r_result_src <= ex_result_src;
            r_alu_result <= w_result;
            r_write_data <= w_rd2_fwd;
            r_imm_ext    <= {LANES{ex_imm_ext}};
            r_pc_plus_4  <= ex_pc_plus_4;
            r_rd         <= ex_rd;
        end
    end

    assign mem_instr      = r_instr;
    assign mem_reg_write  = r_reg_write;
    assign mem_mem_write  = r_mem_write;
    assign mem_mem_read   = r_mem_read;
    assign mem_vector_op  = r_vector_op;
    assign mem_result_src = r_result_src;
    assign mem_alu_result = r_alu_result;
    assign mem_write_data = r_write_data;
    assign mem_imm_ext    = r_imm_ext;
    assign mem_pc_plus_4  = r_pc_plus_4;
    assign mem_rd         = r_rd;
endmodule

// File: tb/tb_stage_execute_vmc.sv
// Testbench for stage_execute_vmc: directed vectors, scoreboard queue of
// expected EX/MEM captures, monitor keyed on a change of mem_instr.
module tb_stage_execute_vmc;
    localparam int         LANES = 4;
    localparam int         VW    = 32 * LANES;
    localparam logic [3:0] MUL   = 4'b1010;
    localparam logic [3:0] ADD   = 4'd0;
    localparam logic [3:0] SUB   = 4'd1;

    logic          clk;
    logic          reset;
    logic          mem_clear, mem_stall, ex_flush;
    logic [31:0]   ex_instr;
    logic          ex_reg_write, ex_mem_write, ex_mem_read, ex_jump, ex_jump_cond;
    logic          ex_alu_src_op1, ex_alu_src_op2, ex_pc_target_src, ex_vector_op;
    logic [2:0]    ex_jump_cond_type;
    logic [3:0]    ex_alu_control;
    logic [1:0]    ex_result_src;
    logic [31:0]   ex_pc, ex_pc_plus_4, ex_imm_ext;
    logic [VW-1:0] ex_rd1, ex_rd2, wb_result;
    logic [4:0]    ex_rd;
    logic [1:0]    ex_op1_forward, ex_op2_forward;
    logic [31:0]   mem_instr;
    logic          mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op;
    logic [1:0]    mem_result_src;
    logic [VW-1:0] mem_alu_result, mem_write_data, mem_imm_ext;
    logic [31:0]   mem_pc_plus_4;
    logic [4:0]    mem_rd;
    logic          ex_pc_src;
    logic [31:0]   ex_pc_target;
    logic          ex_busy;

    stage_execute_vmc #(
        .LANES    (LANES),
        .MUL_STEP (8),
        .MUL_CODE (MUL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_clear         (mem_clear),
        .mem_stall         (mem_stall),
        .ex_flush          (ex_flush),
        .ex_instr          (ex_instr),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_write      (ex_mem_write),
        .ex_mem_read       (ex_mem_read),
        .ex_jump           (ex_jump),
        .ex_jump_cond      (ex_jump_cond),
        .ex_alu_src_op1    (ex_alu_src_op1),
        .ex_alu_src_op2    (ex_alu_src_op2),
        .ex_pc_target_src  (ex_pc_target_src),
        .ex_vector_op      (ex_vector_op),
        .ex_jump_cond_type (ex_jump_cond_type),
        .ex_alu_control    (ex_alu_control),
        .ex_result_src     (ex_result_src),
        .ex_pc             (ex_pc),
        .ex_pc_plus_4      (ex_pc_plus_4),
        .ex_imm_ext        (ex_imm_ext),
        .ex_rd1            (ex_rd1),
        .ex_rd2            (ex_rd2),
        .ex_rd             (ex_rd),
        .wb_result         (wb_result),
        .ex_op1_forward    (ex_op1_forward),
        .ex_op2_forward    (ex_op2_forward),
        .mem_instr         (mem_instr),
        .mem_reg_write     (mem_reg_write),
        .mem_mem_write     (mem_mem_write),
        .mem_mem_read      (mem_mem_read),
        .mem_vector_op     (mem_vector_op),
        .mem_result_src    (mem_result_src),
        .mem_alu_result    (mem_alu_result),
        .mem_write_data    (mem_write_data),
        .mem_imm_ext       (mem_imm_ext),
        .mem_pc_plus_4     (mem_pc_plus_4),
        .mem_rd            (mem_rd),
        .ex_pc_src         (ex_pc_src),
        .ex_pc_target      (ex_pc_target),
        .ex_busy           (ex_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   instr;
        logic [VW-1:0] alu;
        logic [VW-1:0] wdata;
        logic [4:0]    rd;
        logic          rw;
        logic          mw;
        logic          vec;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] v4(input logic [31:0] l3, input logic [31:0] l2,
                                         input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic push(input logic [31:0] instr, input logic [VW-1:0] alu,
                        input logic [VW-1:0] wdata, input logic [4:0] rd,
                        input logic rw, input logic mw, input logic vec);
        exp_t e;
        e.instr = instr; e.alu = alu; e.wdata = wdata; e.rd = rd;
        e.rw = rw; e.mw = mw; e.vec = vec;
        sb_q.push_back(e);
    endtask

    task automatic clr();
        mem_clear = 0; mem_stall = 0; ex_flush = 0; ex_instr = '0;
        ex_reg_write = 0; ex_mem_write = 0; ex_mem_read = 0; ex_jump = 0; ex_jump_cond = 0;
        ex_alu_src_op1 = 0; ex_alu_src_op2 = 0; ex_pc_target_src = 0; ex_vector_op = 0;
        ex_jump_cond_type = '0; ex_alu_control = ADD; ex_result_src = '0;
        ex_pc = '0; ex_pc_plus_4 = '0; ex_imm_ext = '0;
        ex_rd1 = '0; ex_rd2 = '0; wb_result = '0; ex_rd = '0;
        ex_op1_forward = '0; ex_op2_forward = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (ex_busy && n < 20) begin
            n++;
            step();
        end
    endtask

    // Monitor: each new non-zero tag in EX/MEM is one capture
    initial begin
        logic [31:0] prev;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mem_instr != 32'd0 && mem_instr != prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got instr %h expected none", mem_instr);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_instr", VW'(mem_instr), VW'(e.instr));
                    chk("sb_alu_result", mem_alu_result, e.alu);
                    chk("sb_write_data", mem_write_data, e.wdata);
                    chk("sb_rd", VW'(mem_rd), VW'(e.rd));
                    chk("sb_reg_write", VW'(mem_reg_write), VW'(e.rw));
                    chk("sb_mem_write", VW'(mem_mem_write), VW'(e.mw));
                    chk("sb_vector_op", VW'(mem_vector_op), VW'(e.vec));
                end
            end
            prev = mem_instr;
        end
    end

    initial begin
        int n;
        clr();
        reset = 1;
        ex_jump = 1; ex_reg_write = 1; ex_instr = 32'hDEAD;
        step();
        step();
        chk("reset_mem_instr", VW'(mem_instr), '0);
        chk("reset_mem_reg_write", VW'(mem_reg_write), '0);
        chk("reset_mem_alu_result", mem_alu_result, '0);
        chk("reset_ex_busy", VW'(ex_busy), '0);
        chk("reset_ex_pc_src", VW'(ex_pc_src), '0);
        reset = 0;
        clr();

        // vector add
        ex_instr = 32'h11; ex_reg_write = 1; ex_vector_op = 1; ex_alu_src_op1 = 1;
        ex_rd1 = v4(4, 3, 2, 1); ex_rd2 = v4(40, 30, 20, 10); ex_rd = 5;
        push(32'h11, v4(44, 33, 22, 11), v4(40, 30, 20, 10), 5, 1, 0, 1);
        step();
        chk("add_latency1", mem_alu_result, v4(44, 33, 22, 11));

        // full-width MEM forward on both operands
        ex_instr = 32'h12; ex_op1_forward = 2'b10; ex_op2_forward = 2'b10;
        ex_rd1 = v4(9, 9, 9, 9); ex_rd2 = v4(9, 9, 9, 9); ex_rd = 6;
        push(32'h12, v4(88, 66, 44, 22), v4(44, 33, 22, 11), 6, 1, 0, 1);
        step();

        // scalar add, lane 0 broadcast
        ex_instr = 32'h13; ex_op1_forward = 2'b00; ex_op2_forward = 2'b00; ex_vector_op = 0;
        ex_rd1 = v4(100, 100, 100, 3); ex_rd2 = v4(200, 200, 200, 4); ex_rd = 7;
        push(32'h13, v4(7, 7, 7, 7), v4(200, 200, 200, 4), 7, 1, 0, 0);
        step();

        // WB forward op1, scalar MEM forward op2
        ex_instr = 32'h14; ex_vector_op = 1; ex_op1_forward = 2'b01; ex_op2_forward = 2'b10;
        wb_result = v4(400, 300, 200, 100); ex_rd2 = v4(99, 99, 99, 99); ex_rd = 8;
        push(32'h14, v4(407, 307, 207, 107), v4(7, 7, 7, 7), 8, 1, 0, 1);
        step();

        // vector sub with replicated immediate
        ex_instr = 32'h15; ex_op1_forward = 2'b00; ex_op2_forward = 2'b00;
        ex_alu_control = SUB; ex_alu_src_op2 = 1; ex_imm_ext = 5;
        ex_rd1 = v4(50, 40, 30, 20); ex_rd2 = v4(1, 2, 3, 4); ex_rd = 9;
        push(32'h15, v4(45, 35, 25, 15), v4(1, 2, 3, 4), 9, 1, 0, 1);
        step();

        // store forces scalar select even with vector_op set
        ex_instr = 32'h16; ex_alu_control = ADD; ex_mem_write = 1; ex_reg_write = 0;
        ex_imm_ext = 32'h100; ex_rd1 = v4(4, 3, 2, 1); ex_rd2 = v4(10, 11, 12, 13); ex_rd = 10;
        push(32'h16, v4(32'h101, 32'h101, 32'h101, 32'h101), v4(10, 11, 12, 13), 10, 0, 1, 1);
        step();

        // stall hold then release
        clr();
        ex_instr = 32'h17; ex_reg_write = 1; ex_vector_op = 1; ex_alu_src_op1 = 1;
        ex_rd1 = v4(1, 1, 1, 1); ex_rd2 = v4(2, 2, 2, 2); ex_rd = 11;
        push(32'h17, v4(3, 3, 3, 3), v4(2, 2, 2, 2), 11, 1, 0, 1);
        step();
        ex_instr = 32'h18; ex_rd1 = v4(5, 5, 5, 5); ex_rd2 = v4(5, 5, 5, 5); ex_rd = 12;
        mem_stall = 1;
        step();
        chk("stall_hold_instr", VW'(mem_instr), VW'(32'h17));
        chk("stall_hold_alu", mem_alu_result, v4(3, 3, 3, 3));
        mem_stall = 0;
        push(32'h18, v4(10, 10, 10, 10), v4(5, 5, 5, 5), 12, 1, 0, 1);
        step();

        // clear loads a bubble
        ex_instr = 32'h19; mem_clear = 1;
        step();
        chk("clear_instr", VW'(mem_instr), '0);
        chk("clear_reg_write", VW'(mem_reg_write), '0);
        chk("clear_rd", VW'(mem_rd), '0);

        // branches (untagged, not scoreboarded)
        clr();
        ex_jump_cond = 1; ex_jump_cond_type = 3'b000; ex_alu_control = SUB; ex_alu_src_op1 = 1;
        ex_rd1 = v4(0, 0, 0, 32'h55); ex_rd2 = v4(0, 0, 0, 32'h55); ex_pc = 32'h100; ex_imm_ext = 32'h20;
        #1;
        chk("beq_pc_src", VW'(ex_pc_src), VW'(1'b1));
        chk("beq_pc_target", VW'(ex_pc_target), VW'(32'h120));
        ex_jump_cond_type = 3'b001;
        #1;
        chk("bne_pc_src", VW'(ex_pc_src), VW'(1'b0));
        ex_rd1 = v4(0, 0, 0, 32'hFFFF_FFFF); ex_rd2 = v4(0, 0, 0, 1); ex_jump_cond_type = 3'b100;
        #1;
        chk("blt_pc_src", VW'(ex_pc_src), VW'(1'b1));
        ex_jump_cond_type = 3'b110;
        #1;
        chk("bltu_pc_src", VW'(ex_pc_src), VW'(1'b0));
        ex_jump_cond = 0; ex_jump = 1; ex_pc_target_src = 1; ex_alu_control = ADD;
        ex_alu_src_op2 = 1; ex_rd1 = v4(0, 0, 0, 32'h200);
        #1;
        chk("jalr_pc_src", VW'(ex_pc_src), VW'(1'b1));
        chk("jalr_pc_target", VW'(ex_pc_target), VW'(32'h220));
        clr();
        step();

`ifdef EX_MUL_EN
        // vector multiply through the FSM
        ex_instr = 32'h20; ex_alu_control = MUL; ex_vector_op = 1; ex_alu_src_op1 = 1;
        ex_reg_write = 1; ex_rd = 13;
        ex_rd1 = v4(32'h10000, 5, 32'hFFFF, 3); ex_rd2 = v4(32'h10000, 0, 32'h10001, 4);
        push(32'h20, v4(0, 0, 32'hFFFF_FFFF, 12), v4(32'h10000, 0, 32'h10001, 4), 13, 1, 0, 1);
        #1;
        wait_busy(n);
        chk("mul_busy_cycles", VW'(n), VW'(5));
        step();
        clr();

        // scalar multiply held in DONE by mem_stall
        ex_instr = 32'h21; ex_alu_control = MUL; ex_alu_src_op1 = 1; ex_reg_write = 1; ex_rd = 14;
        ex_rd1 = v4(0, 0, 0, 32'h1234_5678); ex_rd2 = v4(0, 0, 0, 32'h10);
        push(32'h21, v4(32'h2345_6780, 32'h2345_6780, 32'h2345_6780, 32'h2345_6780),
             v4(0, 0, 0, 32'h10), 14, 1, 0, 0);
        #1;
        wait_busy(n);
        chk("mulst_busy_cycles", VW'(n), VW'(5));
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mulst_done_busy", VW'(ex_busy), '0);
            chk("mulst_hold_instr", VW'(mem_instr), '0);
            step();
        end
        mem_stall = 0;
        #1;
        chk("mulst_release_busy", VW'(ex_busy), '0);
        step();
        clr();

        // flush in the second BUSY cycle
        ex_instr = 32'h22; ex_alu_control = MUL; ex_vector_op = 1; ex_alu_src_op1 = 1;
        ex_reg_write = 1; ex_rd = 15; ex_rd1 = v4(1, 2, 3, 4); ex_rd2 = v4(5, 6, 7, 8);
        #1;
        chk("flush_start_busy", VW'(ex_busy), VW'(1'b1));
        step();
        step();
        chk("flush_busy2", VW'(ex_busy), VW'(1'b1));
        ex_flush = 1;
        #1;
        chk("flush_busy_drop", VW'(ex_busy), '0);
        step();
        clr();
        #1;
        chk("flush_idle_busy", VW'(ex_busy), '0);
        chk("flush_bubble_instr", VW'(mem_instr), '0);
        chk("flush_bubble_rw", VW'(mem_reg_write), '0);

        // ordinary op right after the abort
        ex_instr = 32'h23; ex_reg_write = 1; ex_vector_op = 1; ex_alu_src_op1 = 1; ex_rd = 16;
        ex_rd1 = v4(1, 2, 3, 4); ex_rd2 = v4(1, 1, 1, 1);
        push(32'h23, v4(2, 3, 4, 5), v4(1, 1, 1, 1), 16, 1, 0, 1);
        step();

        // reset mid-multiply
        ex_instr = 32'h24; ex_alu_control = MUL; ex_rd = 17;
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        clr();
        #1;
        chk("rstmul_busy", VW'(ex_busy), '0);
        chk("rstmul_instr", VW'(mem_instr), '0);
`else
        // multiply as a single-cycle ALU op
        ex_instr = 32'h20; ex_alu_control = MUL; ex_vector_op = 1; ex_alu_src_op1 = 1;
        ex_reg_write = 1; ex_rd = 13;
        ex_rd1 = v4(32'h10000, 5, 32'hFFFF, 3); ex_rd2 = v4(32'h10000, 0, 32'h10001, 4);
        push(32'h20, v4(0, 0, 32'hFFFF_FFFF, 12), v4(32'h10000, 0, 32'h10001, 4), 13, 1, 0, 1);
        #1;
        chk("mul_no_busy", VW'(ex_busy), '0);
        step();
        chk("mul_latency1", mem_alu_result, v4(0, 0, 32'hFFFF_FFFF, 12));
        ex_instr = 32'h21; ex_vector_op = 0; ex_rd = 14;
        ex_rd1 = v4(0, 0, 0, 32'h1234_5678); ex_rd2 = v4(0, 0, 0, 32'h10);
        push(32'h21, v4(32'h2345_6780, 32'h2345_6780, 32'h2345_6780, 32'h2345_6780),
             v4(0, 0, 0, 32'h10), 14, 1, 0, 0);
        step();
        clr();
`endif

        step();
        step();
        chk("sb_drained", VW'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
